// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP check engine: access kinds, error-capture record,
// error-type codes, FSM states and the access-to-ttype encoding.
package rv_iopmp_pkg;

   typedef enum logic [1:0] {
      ACCESS_NONE  = 2'd0,
      ACCESS_READ  = 2'd1,
      ACCESS_WRITE = 2'd2,
      ACCESS_EXEC  = 2'd3
   } access_t;

   localparam logic [2:0] ETYPE_NO_ERROR      = 3'd0;
   localparam logic [2:0] ETYPE_ILLEGAL_READ  = 3'd1;
   localparam logic [2:0] ETYPE_ILLEGAL_WRITE = 3'd2;
   localparam logic [2:0] ETYPE_ILLEGAL_EXEC  = 3'd3;
   localparam logic [2:0] ETYPE_PARTIAL_HIT   = 3'd4;
   localparam logic [2:0] ETYPE_NOT_HIT       = 3'd5;
   localparam logic [2:0] ETYPE_UNKNOWN_SID   = 3'd6;

   localparam int unsigned ERR_SID_W = 16;
   localparam int unsigned ERR_EID_W = 16;

   typedef struct packed {
      logic                 error_detected;
      logic [2:0]           etype;
      logic [1:0]           ttype;
      logic [ERR_SID_W-1:0] sid;
      logic [ERR_EID_W-1:0] eid;
      logic [31:0]          reqaddr;
      logic [31:0]          reqaddrh;
   } error_capture_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_RESP  = 2'd2
   } check_state_e;

   // Anything that is neither a write nor a fetch is reported as a read.
   function automatic logic [1:0] ttype_enc(input access_t acc);
      case (acc)
         ACCESS_WRITE: return 2'd2;
         ACCESS_EXEC:  return 2'd3;
         default:      return 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first requester at or after
// the pointer; the registered pointer moves past the winner when i_advance is high.
module rv_iopmp_rr_arbiter #(
   parameter int unsigned  NUM_CHANNELS = 2,
   localparam int unsigned IDX_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_CHANNELS-1:0] i_req,
   input  logic                    i_advance,
   output logic [NUM_CHANNELS-1:0] o_gnt,
   output logic [IDX_W-1:0]        o_gnt_idx
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;
   int unsigned      w_sum;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_cand    = '0;
      w_sum     = 0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         w_sum = 32'(r_ptr) + i;
         if (w_sum >= NUM_CHANNELS) w_sum = w_sum - NUM_CHANNELS;
         w_cand = IDX_W'(w_sum);
         if (!w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_gnt_idx     = w_cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= (32'(o_gnt_idx) == NUM_CHANNELS - 1) ? '0 : o_gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/rv_iopmp_check_engine.sv
// Multi-channel IOPMP checker: round-robin accept, one entry chunk per cycle, response
// 2..NUM_ITER+1 cycles after accept; response held until the granted channel's rsp_ready_i.
module rv_iopmp_check_engine
   import rv_iopmp_pkg::*;
#(
   parameter int unsigned  ADDR_WIDTH             = 64,
   parameter int unsigned  DATA_WIDTH             = 64,
   parameter int unsigned  SID_WIDTH              = 8,
   parameter int unsigned  NUMBER_ENTRIES         = 20,
   parameter int unsigned  NUMBER_ENTRY_ANALYZERS = 8,
   parameter int unsigned  NUM_CHANNELS           = 2,
   parameter bit           DISABLED_ALLOW         = 1'b0,
   localparam int unsigned NB_W                   = $clog2(DATA_WIDTH / 8) + 1,
   localparam int unsigned OFF_W                  = (NUMBER_ENTRIES > 1) ? $clog2(NUMBER_ENTRIES) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              iopmp_enabled_i,
   input  logic                              cfg_update_i,
   input  logic [NUM_CHANNELS-1:0]           req_valid_i,
   output logic [NUM_CHANNELS-1:0]           req_ready_o,
   input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_CHANNELS*NB_W-1:0]      req_nbytes_i,
   input  logic [NUM_CHANNELS*SID_WIDTH-1:0] req_sid_i,
   input  access_t [NUM_CHANNELS-1:0]        req_access_i,
   output logic                              chk_en_o,
   output logic [OFF_W-1:0]                  chk_offset_o,
   output logic [NUMBER_ENTRY_ANALYZERS-1:0] chk_lane_mask_o,
   output logic [ADDR_WIDTH-1:0]             chk_addr_o,
   output logic [NB_W-1:0]                   chk_nbytes_o,
   output logic [SID_WIDTH-1:0]              chk_sid_o,
   output access_t                           chk_access_o,
   input  logic                              chk_hit_i,
   input  logic                              chk_allow_i,
   input  logic [2:0]                        chk_etype_i,
   input  logic [15:0]                       chk_eidx_i,
   output logic [NUM_CHANNELS-1:0]           rsp_valid_o,
   input  logic [NUM_CHANNELS-1:0]           rsp_ready_i,
   output logic                              rsp_allow_o,
   output error_capture_t                    rsp_err_o
);

   localparam int unsigned NUM_ITER = (NUMBER_ENTRIES + NUMBER_ENTRY_ANALYZERS - 1) / NUMBER_ENTRY_ANALYZERS;
   localparam int unsigned ITER_W   = $clog2(NUM_ITER + 1);
   localparam int unsigned IDX_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   check_state_e          r_state, w_state_nxt;
   logic [ITER_W-1:0]     r_iter, w_iter_nxt;
   logic [IDX_W-1:0]      r_gnt_idx;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [NB_W-1:0]       r_nbytes;
   logic [SID_WIDTH-1:0]  r_sid;
   access_t               r_access;
   logic                  r_allow, w_allow_nxt;
   error_capture_t        r_err, w_err_nxt, w_err_fill;

   logic [NUM_CHANNELS-1:0] w_gnt;
   logic [IDX_W-1:0]        w_gnt_idx;
   logic                    w_accept;
   int unsigned             w_offset;

   rv_iopmp_rr_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_req     (req_valid_i),
      .i_advance (w_accept),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   assign w_accept    = (r_state == ST_IDLE) && (|w_gnt);
   assign req_ready_o = (r_state == ST_IDLE) ? w_gnt : '0;
   assign rsp_valid_o = (r_state == ST_RESP) ? (NUM_CHANNELS'(1) << r_gnt_idx) : '0;
   assign rsp_allow_o = r_allow;
   assign rsp_err_o   = r_err;

   assign chk_en_o     = (r_state == ST_CHECK);
   assign w_offset     = 32'(r_iter) * NUMBER_ENTRY_ANALYZERS;
   assign chk_offset_o = OFF_W'(w_offset);
   assign chk_addr_o   = r_addr;
   assign chk_nbytes_o = r_nbytes;
   assign chk_sid_o    = r_sid;
   assign chk_access_o = r_access;

   // The last chunk may run past the table; those lanes are masked off.
   always_comb begin
      chk_lane_mask_o = '0;
      for (int unsigned i = 0; i < NUMBER_ENTRY_ANALYZERS; i++) begin
         chk_lane_mask_o[i] = (w_offset + i) < NUMBER_ENTRIES;
      end
   end

   always_comb begin
      w_err_fill                = '0;
      w_err_fill.error_detected = 1'b1;
      w_err_fill.ttype          = ttype_enc(r_access);
      w_err_fill.sid            = ERR_SID_W'(r_sid);
      w_err_fill.reqaddr        = r_addr[31:0];
      w_err_fill.reqaddrh       = r_addr[63:32];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_iter_nxt  = r_iter;
      w_allow_nxt = r_allow;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_iter_nxt  = '0;
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (cfg_update_i) begin
               w_iter_nxt = '0;
            end else if (!iopmp_enabled_i) begin
               w_allow_nxt = DISABLED_ALLOW;
               w_err_nxt   = '0;
               w_state_nxt = ST_RESP;
            end else if (chk_hit_i) begin
               w_allow_nxt     = chk_allow_i;
               w_err_nxt       = w_err_fill;
               w_err_nxt.etype = chk_etype_i;
               w_err_nxt.eid   = chk_eidx_i;
               if (chk_allow_i) w_err_nxt = '0;
               w_state_nxt = ST_RESP;
            end else if (r_iter == ITER_W'(NUM_ITER - 1)) begin
               w_allow_nxt     = 1'b0;
               w_err_nxt       = w_err_fill;
               w_err_nxt.etype = ETYPE_NOT_HIT;
               w_err_nxt.eid   = '0;
               w_state_nxt     = ST_RESP;
            end else begin
               w_iter_nxt = r_iter + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i[r_gnt_idx]) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_iter    <= '0;
         r_gnt_idx <= '0;
         r_addr    <= '0;
         r_nbytes  <= '0;
         r_sid     <= '0;
         r_access  <= ACCESS_NONE;
         r_allow   <= 1'b0;
         r_err     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_iter  <= w_iter_nxt;
         r_allow <= w_allow_nxt;
         r_err   <= w_err_nxt;
         if (w_accept) begin
            r_gnt_idx <= w_gnt_idx;
            r_addr    <= req_addr_i[32'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_nbytes  <= req_nbytes_i[32'(w_gnt_idx)*NB_W +: NB_W];
            r_sid     <= req_sid_i[32'(w_gnt_idx)*SID_WIDTH +: SID_WIDTH];
            r_access  <= req_access_i[w_gnt_idx];
         end
      end
   end

endmodule

// File: tb/tb_rv_iopmp_check_engine.sv
// Bench for rv_iopmp_check_engine: acts as the analyzer datapath and both requesters,
// predicting grant order, chunk sweep, latency and response from the decision rules.
`timescale 1ns/1ps
module tb_rv_iopmp_check_engine;
   import rv_iopmp_pkg::*;

   localparam int NCH   = 2;
   localparam int NENT  = 20;
   localparam int NAN   = 8;
   localparam int NITER = (NENT + NAN - 1) / NAN;
   localparam bit DIS_ALLOW = 1'b0;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic           iopmp_enabled_i;
   logic           cfg_update_i;
   logic [1:0]     req_valid_i;
   logic [1:0]     req_ready_o;
   logic [127:0]   req_addr_i;
   logic [7:0]     req_nbytes_i;
   logic [15:0]    req_sid_i;
   access_t [1:0]  req_access_i;
   logic           chk_en_o;
   logic [4:0]     chk_offset_o;
   logic [7:0]     chk_lane_mask_o;
   logic [63:0]    chk_addr_o;
   logic [3:0]     chk_nbytes_o;
   logic [7:0]     chk_sid_o;
   access_t        chk_access_o;
   logic           chk_hit_i;
   logic           chk_allow_i;
   logic [2:0]     chk_etype_i;
   logic [15:0]    chk_eidx_i;
   logic [1:0]     rsp_valid_o;
   logic [1:0]     rsp_ready_i;
   logic           rsp_allow_o;
   error_capture_t rsp_err_o;

   rv_iopmp_check_engine #(
      .ADDR_WIDTH             (64),
      .DATA_WIDTH             (64),
      .SID_WIDTH              (8),
      .NUMBER_ENTRIES         (NENT),
      .NUMBER_ENTRY_ANALYZERS (NAN),
      .NUM_CHANNELS           (NCH),
      .DISABLED_ALLOW         (DIS_ALLOW)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .iopmp_enabled_i (iopmp_enabled_i),
      .cfg_update_i    (cfg_update_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .req_nbytes_i    (req_nbytes_i),
      .req_sid_i       (req_sid_i),
      .req_access_i    (req_access_i),
      .chk_en_o        (chk_en_o),
      .chk_offset_o    (chk_offset_o),
      .chk_lane_mask_o (chk_lane_mask_o),
      .chk_addr_o      (chk_addr_o),
      .chk_nbytes_o    (chk_nbytes_o),
      .chk_sid_o       (chk_sid_o),
      .chk_access_o    (chk_access_o),
      .chk_hit_i       (chk_hit_i),
      .chk_allow_i     (chk_allow_i),
      .chk_etype_i     (chk_etype_i),
      .chk_eidx_i      (chk_eidx_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_allow_o     (rsp_allow_o),
      .rsp_err_o       (rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int rr_ptr   = 0;

   logic [63:0] ch_addr [NCH];
   logic [3:0]  ch_nb   [NCH];
   logic [7:0]  ch_sid  [NCH];
   access_t     ch_acc  [NCH];

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [1:0] m);
      int idx;
      for (int k = 0; k < NCH; k++) begin
         idx = (rr_ptr + k) % NCH;
         if (m[idx]) return idx;
      end
      return 0;
   endfunction

   function automatic logic [1:0] exp_ttype(input access_t a);
      if (a == ACCESS_WRITE) return 2'd2;
      if (a == ACCESS_EXEC) return 2'd3;
      return 2'd1;
   endfunction

   task automatic drive_channels();
      req_addr_i      = {ch_addr[1], ch_addr[0]};
      req_nbytes_i    = {ch_nb[1], ch_nb[0]};
      req_sid_i       = {ch_sid[1], ch_sid[0]};
      req_access_i[0] = ch_acc[0];
      req_access_i[1] = ch_acc[1];
   endtask

   task automatic randomize_channels();
      for (int c = 0; c < NCH; c++) begin
         ch_addr[c] = {$urandom, $urandom};
         ch_nb[c]   = 4'($urandom_range(1, 8));
         ch_sid[c]  = 8'($urandom);
         ch_acc[c]  = access_t'($urandom_range(0, 3));
      end
   endtask

   // One request end to end. hit_chunk == NITER means no chunk hits; cfg_cycle/dis_cycle
   // are cycles counted from the first CHECK cycle (-1 = never).
   task automatic run_txn(input logic [1:0] vmask, input int hit_chunk, input bit hit_allow,
                          input logic [2:0] etype, input logic [15:0] eidx,
                          input int cfg_cycle, input int dis_cycle, input int hold,
                          input bit force_fields, input logic [63:0] f_addr, input access_t f_acc);
      int             g, first_end, end_c, n, chunk, lanes;
      bit             cfg_ok, dis_hit, done;
      logic [1:0]     exp_v;
      logic           exp_allow;
      error_capture_t exp_err;

      g = rr_pick(vmask);
      randomize_channels();
      if (force_fields) begin
         ch_addr[g] = f_addr;
         ch_acc[g]  = f_acc;
      end
      drive_channels();
      req_valid_i     = vmask;
      rsp_ready_i     = 2'b00;
      cfg_update_i    = 1'b0;
      chk_hit_i       = 1'b0;
      iopmp_enabled_i = 1'b1;
      chk_allow_i     = hit_allow;
      chk_etype_i     = etype;
      chk_eidx_i      = eidx;
      exp_v           = 2'b01 << g;

      @(negedge clk_i);
      check_val("req_ready_grant", req_ready_o, exp_v);
      @(posedge clk_i); #1;
      rr_ptr = (g + 1) % NCH;

      first_end = (hit_chunk < NITER) ? hit_chunk : NITER - 1;
      cfg_ok    = (cfg_cycle >= 0) && (cfg_cycle <= first_end);
      end_c     = cfg_ok ? cfg_cycle + 1 + first_end : first_end;
      dis_hit   = 1'b0;
      if (dis_cycle >= 0 && dis_cycle <= end_c) begin
         dis_hit = 1'b1;
         end_c   = (cfg_ok && dis_cycle == cfg_cycle) ? dis_cycle + 1 : dis_cycle;
      end

      exp_err   = '0;
      exp_allow = 1'b0;
      if (dis_hit) begin
         exp_allow = DIS_ALLOW;
      end else if (hit_chunk < NITER && hit_allow) begin
         exp_allow = 1'b1;
      end else begin
         exp_err.error_detected = 1'b1;
         exp_err.ttype          = exp_ttype(ch_acc[g]);
         exp_err.sid            = {8'h00, ch_sid[g]};
         exp_err.reqaddr        = ch_addr[g][31:0];
         exp_err.reqaddrh       = ch_addr[g][63:32];
         exp_err.etype          = (hit_chunk < NITER) ? etype : ETYPE_NOT_HIT;
         exp_err.eid            = (hit_chunk < NITER) ? eidx : 16'd0;
      end

      n    = 0;
      done = 1'b0;
      while (!done) begin
         chunk           = (cfg_ok && n > cfg_cycle) ? n - cfg_cycle - 1 : n;
         cfg_update_i    = cfg_ok && (n == cfg_cycle);
         iopmp_enabled_i = !(dis_cycle >= 0 && n >= dis_cycle);
         chk_hit_i       = (chunk == hit_chunk);
         @(negedge clk_i);
         if (rsp_valid_o != 2'b00) begin
            done = 1'b1;
         end else if (n > 4 * NITER + 4) begin
            check_val("rsp_timeout", rsp_valid_o, exp_v);
            return;
         end else begin
            check_val("chk_en", chk_en_o, 1'b1);
            check_val("req_ready_busy", req_ready_o, 2'b00);
            check_val("chk_fields", {chk_addr_o, chk_nbytes_o, chk_sid_o, chk_access_o},
                      {ch_addr[g], ch_nb[g], ch_sid[g], ch_acc[g]});
            if (chunk < NITER) begin
               lanes = (NENT - chunk * NAN < NAN) ? NENT - chunk * NAN : NAN;
               check_val("chk_offset", chk_offset_o, chunk * NAN);
               check_val("chk_lane_mask", chk_lane_mask_o, (1 << lanes) - 1);
            end
            n++;
            @(posedge clk_i); #1;
         end
      end
      check_val("check_cycles", n, end_c + 1);

      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clk_i);
         check_val("rsp_valid", rsp_valid_o, exp_v);
         check_val("rsp_allow", rsp_allow_o, exp_allow);
         check_val("rsp_err", rsp_err_o, exp_err);
         check_val("req_ready_resp", req_ready_o, 2'b00);
         if (h == hold) rsp_ready_i = exp_v;
         @(posedge clk_i); #1;
         chk_hit_i       = 1'b0;
         iopmp_enabled_i = 1'b1;
         cfg_update_i    = 1'($urandom_range(0, 1));
      end
      rsp_ready_i  = 2'b00;
      cfg_update_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_rsp_valid"}, rsp_valid_o, 2'b00);
      check_val({pfx, "_req_ready"}, req_ready_o, 2'b00);
      check_val({pfx, "_chk_en"}, chk_en_o, 1'b0);
      check_val({pfx, "_chk_offset"}, chk_offset_o, 5'd0);
      check_val({pfx, "_rsp_allow"}, rsp_allow_o, 1'b0);
      check_val({pfx, "_rsp_err"}, rsp_err_o, 102'd0);
      check_val({pfx, "_chk_fields"}, {chk_addr_o, chk_nbytes_o, chk_sid_o, chk_access_o}, 78'd0);
   endtask

   task automatic reset_mid_check();
      randomize_channels();
      drive_channels();
      req_valid_i = 2'b01;
      @(negedge clk_i);
      @(posedge clk_i); #1;
      rr_ptr = 1;
      @(negedge clk_i);
      check_val("chk_en_pre_rst", chk_en_o, 1'b1);
      rst_ni      = 1'b0;
      req_valid_i = 2'b00;
      #1;
      check_reset_outputs("rst_mid");
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      rr_ptr = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         check_val("no_rsp_after_rst", {rsp_valid_o, chk_en_o}, 3'b000);
      end
      @(posedge clk_i); #1;
   endtask

   initial begin
      rst_ni          = 1'b0;
      iopmp_enabled_i = 1'b1;
      cfg_update_i    = 1'b0;
      req_valid_i     = 2'b00;
      rsp_ready_i     = 2'b00;
      chk_hit_i       = 1'b0;
      chk_allow_i     = 1'b0;
      chk_etype_i     = 3'd0;
      chk_eidx_i      = 16'd0;
      randomize_channels();
      drive_channels();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_reset_outputs("reset");
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // read allowed at first chunk
      run_txn(2'b01, 0, 1'b1, 3'd1, 16'd0, -1, -1, 0, 1'b1, 64'h0000_0000_0000_1000, ACCESS_READ);
      // full sweep without a hit
      run_txn(2'b01, NITER, 1'b0, 3'd1, 16'd0, -1, -1, 0, 1'b0, 64'd0, ACCESS_READ);
      // both channels contending, one response back-pressured
      for (int i = 0; i < 4; i++)
         run_txn(2'b11, $urandom_range(0, NITER), 1'($urandom), 3'd1, 16'($urandom),
                 -1, -1, (i == 1) ? 5 : 0, 1'b0, 64'd0, ACCESS_READ);
      // restart during iteration 1 of a no-hit sweep
      run_txn(2'b10, NITER, 1'b0, 3'd1, 16'd0, 1, -1, 0, 1'b0, 64'd0, ACCESS_READ);
      // restart discards a hit in the same cycle
      run_txn(2'b01, 0, 1'b1, 3'd1, 16'd0, 0, -1, 0, 1'b0, 64'd0, ACCESS_READ);
      // disable mid-sweep, and disable coinciding with a restart
      run_txn(2'b01, 2, 1'b1, 3'd1, 16'd0, -1, 1, 0, 1'b0, 64'd0, ACCESS_READ);
      run_txn(2'b01, 1, 1'b0, 3'd1, 16'd0, 0, 0, 0, 1'b0, 64'd0, ACCESS_READ);
      // denied write with split address
      run_txn(2'b10, 1, 1'b0, 3'd2, 16'd13, -1, -1, 1, 1'b1, 64'h0000_0001_8000_0040, ACCESS_WRITE);
      reset_mid_check();
      run_txn(2'b11, 0, 1'b1, 3'd1, 16'd0, -1, -1, 0, 1'b0, 64'd0, ACCESS_READ);

      for (int t = 0; t < 150; t++) begin
         int hc, fe, cc, dc;
         hc = $urandom_range(0, NITER);
         fe = (hc < NITER) ? hc : NITER - 1;
         cc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, fe) : -1;
         dc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
         run_txn(2'($urandom_range(1, 3)), hc, 1'($urandom), 3'($urandom_range(1, 6)),
                 16'($urandom), cc, dc, $urandom_range(0, 3), 1'b0, 64'd0, ACCESS_READ);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
